// File: rtl/corevx_ptw_multilevel.sv
// Multi-level page table walker: resolves a virtual page to a physical page
// by reading 32-bit PTEs over an ArmleoBus master port, with superpages at any level.
module corevx_ptw_multilevel #(
  parameter  int LEVELS   = 2,
  parameter  int CHECK_AD = 1,
  localparam int VA_W     = LEVELS*10+12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            resolve_request,
  output logic            resolve_ack,
  input  logic [VA_W-1:0] resolve_virtual_address,
  input  logic            resolve_write,
  output logic            resolve_done,
  output logic            resolve_pagefault,
  output logic            resolve_accessfault,
  output logic [7:0]      resolve_access_bits,
  output logic [21:0]     resolve_physical_address,
  output logic [1:0]      resolve_level,
  input  logic            satp_mode,
  input  logic [21:0]     satp_ppn,
  output logic            m_transaction,
  output logic [2:0]      m_cmd,
  output logic [33:0]     m_address,
  input  logic            m_transaction_done,
  input  logic [2:0]      m_transaction_response,
  input  logic [31:0]     m_rdata
);
  localparam logic [2:0] CMD_NONE     = 3'd0;
  localparam logic [2:0] CMD_READ     = 3'd1;
  localparam logic [2:0] RESP_SUCCESS = 3'd0;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [21:0] table_ppn_q, table_ppn_d;
  logic [29:0] vpn_q, vpn_d;
  logic        write_q, write_d;
  logic        gap_q, gap_d;
  logic        pf_q, pf_d;
  logic        af_q, af_d;
  logic [7:0]  bits_q, bits_d;
  logic [21:0] ppn_q, ppn_d;
  logic [1:0]  rlvl_q, rlvl_d;

  logic [2:0][9:0] vpn;
  logic [33:0]     va_ext;
  logic [21:0]     pte_ppn, low_mask, leaf_ppn;
  logic            pte_v, pte_r, pte_w, pte_x;
  logic            misaligned, ad_fail, term;
  logic            unused_bits;

  assign vpn      = vpn_q;
  assign va_ext   = 34'(resolve_virtual_address);
  assign pte_ppn  = m_rdata[31:10];
  assign pte_v    = m_rdata[0];
  assign pte_r    = m_rdata[1];
  assign pte_w    = m_rdata[2];
  assign pte_x    = m_rdata[3];
  assign unused_bits = ^{va_ext[11:0], resolve_virtual_address[11:0], m_rdata[9:8]};

  // PPN slices below the current level must be zero for a superpage leaf,
  // and are replaced by the matching VPN slices in the result.
  always_comb begin
    low_mask = '0;
    if (level_q >= 2'd1) low_mask[9:0]   = '1;
    if (level_q >= 2'd2) low_mask[19:10] = '1;
  end

  assign misaligned = |(pte_ppn & low_mask);
  assign leaf_ppn   = (pte_ppn & ~low_mask) | ({2'b00, vpn[1], vpn[0]} & low_mask);
  assign ad_fail    = (CHECK_AD != 0) && (!m_rdata[6] || (write_q && !m_rdata[7]));

  assign resolve_ack   = (state_q == IDLE) && resolve_request;
  assign resolve_done  = (state_q == DONE);
  assign m_transaction = (state_q == READ) && !gap_q;
  assign m_cmd         = m_transaction ? CMD_READ : CMD_NONE;
  assign m_address     = {table_ppn_q, vpn[level_q], 2'b00};

  assign resolve_pagefault        = pf_q;
  assign resolve_accessfault      = af_q;
  assign resolve_access_bits      = bits_q;
  assign resolve_physical_address = ppn_q;
  assign resolve_level            = rlvl_q;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    table_ppn_d = table_ppn_q;
    vpn_d       = vpn_q;
    write_d     = write_q;
    gap_d       = 1'b0;
    pf_d        = pf_q;
    af_d        = af_q;
    bits_d      = bits_q;
    ppn_d       = ppn_q;
    rlvl_d      = rlvl_q;
    term        = 1'b0;
    case (state_q)
      IDLE: begin
        if (resolve_request) begin
          vpn_d   = 30'(resolve_virtual_address[VA_W-1:12]);
          write_d = resolve_write;
          if (!satp_mode) begin
            state_d = DONE;
            pf_d    = 1'b0;
            af_d    = 1'b0;
            bits_d  = 8'hCF;
            ppn_d   = va_ext[33:12];
            rlvl_d  = 2'd0;
          end else begin
            state_d     = READ;
            level_d     = 2'(LEVELS-1);
            table_ppn_d = satp_ppn;
          end
        end
      end
      READ: begin
        if (!gap_q && m_transaction_done) begin
          term = 1'b1;
          pf_d = 1'b0;
          af_d = 1'b0;
          if (m_transaction_response != RESP_SUCCESS)
            af_d = 1'b1;
          else if (!pte_v || (pte_w && !pte_r))
            pf_d = 1'b1;
          else if (pte_r || pte_x)
            pf_d = misaligned || ad_fail;
          else if (level_q == 2'd0)
            pf_d = 1'b1;
          else begin
            // Pointer: descend, leaving the bus idle for one cycle.
            term        = 1'b0;
            pf_d        = pf_q;
            af_d        = af_q;
            level_d     = level_q - 2'd1;
            table_ppn_d = pte_ppn;
            gap_d       = 1'b1;
          end
          if (term) begin
            state_d = DONE;
            bits_d  = m_rdata[7:0];
            ppn_d   = leaf_ppn;
            rlvl_d  = level_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      table_ppn_q <= '0;
      vpn_q       <= '0;
      write_q     <= 1'b0;
      gap_q       <= 1'b0;
      pf_q        <= 1'b0;
      af_q        <= 1'b0;
      bits_q      <= '0;
      ppn_q       <= '0;
      rlvl_q      <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      table_ppn_q <= table_ppn_d;
      vpn_q       <= vpn_d;
      write_q     <= write_d;
      gap_q       <= gap_d;
      pf_q        <= pf_d;
      af_q        <= af_d;
      bits_q      <= bits_d;
      ppn_q       <= ppn_d;
      rlvl_q      <= rlvl_d;
    end
  end
endmodule

// File: tb/tb_corevx_ptw_multilevel.sv
// Bench for the page table walker: a 2-level and a 3-level instance share one
// sparse memory; a walk model predicts each result and a monitor checks every done.
module tb_corevx_ptw_multilevel;
  localparam logic [2:0] CMD_NONE = 3'd0, CMD_READ = 3'd1, RSP_OK = 3'd0, RSP_UNK = 3'd3;

  typedef struct packed {
    logic        pf;
    logic        af;
    logic [7:0]  bits;
    logic [21:0] ppn;
    logic [1:0]  lvl;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req[2], ack[2], wr[2], done[2], pf[2], af[2], mode[2], txn[2];
  logic        mdone[2] = '{1'b0, 1'b0};
  logic [7:0]  bits[2];
  logic [21:0] ppn[2], root[2];
  logic [1:0]  lvl[2];
  logic [2:0]  cmd[2];
  logic [2:0]  rsp[2] = '{3'd0, 3'd0};
  logic [33:0] addr[2];
  logic [31:0] rdata[2] = '{32'd0, 32'd0};
  logic [31:0] va2;
  logic [41:0] va3;

  corevx_ptw_multilevel #(.LEVELS(2), .CHECK_AD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .resolve_request(req[0]), .resolve_ack(ack[0]),
    .resolve_virtual_address(va2), .resolve_write(wr[0]), .resolve_done(done[0]),
    .resolve_pagefault(pf[0]), .resolve_accessfault(af[0]), .resolve_access_bits(bits[0]),
    .resolve_physical_address(ppn[0]), .resolve_level(lvl[0]), .satp_mode(mode[0]),
    .satp_ppn(root[0]), .m_transaction(txn[0]), .m_cmd(cmd[0]), .m_address(addr[0]),
    .m_transaction_done(mdone[0]), .m_transaction_response(rsp[0]), .m_rdata(rdata[0]));

  corevx_ptw_multilevel #(.LEVELS(3), .CHECK_AD(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .resolve_request(req[1]), .resolve_ack(ack[1]),
    .resolve_virtual_address(va3), .resolve_write(wr[1]), .resolve_done(done[1]),
    .resolve_pagefault(pf[1]), .resolve_accessfault(af[1]), .resolve_access_bits(bits[1]),
    .resolve_physical_address(ppn[1]), .resolve_level(lvl[1]), .satp_mode(mode[1]),
    .satp_ppn(root[1]), .m_transaction(txn[1]), .m_cmd(cmd[1]), .m_address(addr[1]),
    .m_transaction_done(mdone[1]), .m_transaction_response(rsp[1]), .m_rdata(rdata[1]));

  logic [31:0] mem  [longint];
  logic [2:0]  rmap [longint];
  res_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Walk model: follows the table rules with plain arithmetic over the memory map.
  function automatic res_t walk(input logic [41:0] va, input bit w, input bit m,
                                input logic [21:0] rt, input int levels);
    res_t r;
    longint tbl;
    r = '0;
    tbl = longint'(rt);
    if (!m) begin
      r.bits = 8'hCF;
      r.ppn  = va[33:12];
      return r;
    end
    for (int l = levels-1; l >= 0; l--) begin
      longint vpn, idx, mask, lp;
      logic [31:0] pte;
      vpn  = longint'((va >> (12 + 10*l)) & 42'h3FF);
      idx  = tbl*1024 + vpn;
      pte  = mem.exists(idx) ? mem[idx] : 32'h0;
      mask = (longint'(1) << (10*l)) - 1;
      lp   = longint'(pte >> 10);
      r.bits = pte[7:0];
      r.lvl  = 2'(l);
      if (rmap.exists(idx) && rmap[idx] != RSP_OK) begin r.af = 1'b1; return r; end
      if (!pte[0] || (pte[2] && !pte[1])) begin r.pf = 1'b1; return r; end
      if (pte[1] || pte[3]) begin
        if ((lp & mask) != 0 || !pte[6] || (w && !pte[7])) r.pf = 1'b1;
        else r.ppn = 22'((lp & ~mask) | (longint'(va >> 12) & mask));
        return r;
      end
      if (l == 0) begin r.pf = 1'b1; return r; end
      tbl = lp;
    end
    return r;
  endfunction

  // Bus responder: one wait cycle, then completion with the stored PTE.
  int wcnt[2] = '{0, 0};
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (txn[d] && !mdone[d]) begin
        if (wcnt[d] >= 1) begin
          longint idx;
          idx = longint'(addr[d] >> 2);
          mdone[d] = 1'b1;
          rsp[d]   = rmap.exists(idx) ? rmap[idx] : RSP_OK;
          rdata[d] = mem.exists(idx) ? mem[idx] : 32'h0;
        end else wcnt[d]++;
      end else begin
        mdone[d] = 1'b0;
        wcnt[d]  = 0;
      end
    end
  end

  // Monitor: bus protocol every cycle, results on every done strobe.
  logic        pdone[2] = '{1'b0, 1'b0}, ptxn[2] = '{1'b0, 1'b0}, pmd[2] = '{1'b0, 1'b0};
  logic [33:0] paddr[2];
  always @(negedge clk) begin
    res_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        chk("m_cmd", {61'd0, cmd[d]}, txn[d] ? 64'(CMD_READ) : 64'(CMD_NONE));
        if (txn[d] && ptxn[d] && !pmd[d]) chk("addr_stable", 64'(addr[d]), 64'(paddr[d]));
        if (done[d]) begin
          chk("done_one_cycle", 64'(pdone[d]), 64'd0);
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done dut%0d", d);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("pagefault", 64'(pf[d]), 64'(e.pf));
            chk("accessfault", 64'(af[d]), 64'(e.af));
            if (!e.pf && !e.af) begin
              chk("access_bits", 64'(bits[d]), 64'(e.bits));
              chk("ppn", 64'(ppn[d]), 64'(e.ppn));
              chk("level", 64'(lvl[d]), 64'(e.lvl));
            end
          end
        end
      end
      pdone[d] <= done[d];
      ptxn[d]  <= txn[d];
      pmd[d]   <= mdone[d];
      paddr[d] <= addr[d];
    end
  end

  // One translation; request stays high with scrambled inputs until done to
  // show that nothing is re-acked or re-sampled mid-walk.
  task automatic run(input int d, input logic [41:0] va, input bit w, input bit m,
                     input logic [21:0] rt, input int exp_lat, input string nm);
    res_t e;
    int cyc;
    e = walk(va, w, m, rt, d == 0 ? 2 : 3);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    req[d] = 1'b1; wr[d] = w; mode[d] = m; root[d] = rt;
    if (d == 0) va2 = va[31:0]; else va3 = va;
    #1 chk({nm, "_ack"}, 64'(ack[d]), 64'd1);
    @(posedge clk); #1;
    if (d == 0) va2 = ~va2; else va3 = ~va3;
    wr[d] = ~w; mode[d] = ~m; root[d] = ~rt;
    cyc = 1;
    while (!done[d] && cyc < 30) begin
      chk({nm, "_noack"}, 64'(ack[d]), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    if (!done[d]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no done after %0d cycles", nm, cyc);
    end else begin
      chk({nm, "_noack_done"}, 64'(ack[d]), 64'd0);
      if (exp_lat != 0) chk({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
    end
    req[d] = 1'b0;
  endtask

  logic [7:0] mflags [5] = '{8'hCF, 8'hC7, 8'hCB, 8'hC3, 8'hC9};
  res_t pin;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; wr[d] = 0; mode[d] = 0; root[d] = '0;
    end
    va2 = '0; va3 = '0;
    // 2-level tables: root PPN 0, second-level tables at PPN 1 and 2.
    mem[1] = 32'h0000_0401; rmap[1] = RSP_UNK;
    mem[2] = 32'h0000_0401; rmap[1024] = RSP_UNK;
    for (int k = 0; k < 5; k++) mem[3+k] = 32'h0010_0000 | 32'(mflags[k]);
    mem[8] = 32'h0000_0401; mem[1025] = 32'h048D_14C7;
    mem[9] = 32'h0010_04CF;
    mem[10] = 32'h0; mem[11] = 32'h0010_00C5; mem[12] = 32'h0010_00CD;
    mem[13] = 32'h0000_0801;
    mem[2048] = 32'h0; mem[2049] = 32'h0000_04C5; mem[2050] = 32'h0000_04CD;
    mem[2051] = 32'h0000_0C01;
    mem[14] = 32'h0010_008F; mem[15] = 32'h0010_004F;
    // 3-level tables: root PPN 3, then PPN 4, PPN 5.
    mem[3073] = 32'h4000_00CF;
    mem[3074] = 32'h0000_1001; mem[4101] = 32'h0000_1401; mem[5126] = 32'h0AAF_34C3;
    mem[3075] = 32'h4010_00CF;

    // Hand-computed pins on the model itself.
    pin = walk(42'h0_00D5_5000, 0, 1, 22'h0, 2); chk("pin_mega_ppn", 64'(pin.ppn), 64'h555);
    pin = walk(42'h0_0200_1000, 0, 1, 22'h0, 2); chk("pin_4k_ppn", 64'(pin.ppn), 64'h12345);
    chk("pin_4k_lvl", 64'(pin.lvl), 64'd0);
    pin = walk(42'h0_0040_0001, 0, 1, 22'h0, 2); chk("pin_af", 64'(pin.af), 64'd1);
    pin = walk(42'h0_0240_0000, 0, 1, 22'h0, 2); chk("pin_misalign", 64'(pin.pf), 64'd1);
    pin = walk(42'h1_AA95_5000, 0, 1, 22'h3, 3); chk("pin_giga_ppn", 64'(pin.ppn), 64'h1AA955);
    pin = walk(42'h0_1234_5001, 0, 0, 22'h0, 2); chk("pin_bare_ppn", 64'(pin.ppn), 64'h12345);

    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_done", 64'(done[d]), 64'd0);
      chk("rst_txn", 64'(txn[d]), 64'd0);
      chk("rst_cmd", 64'(cmd[d]), 64'(CMD_NONE));
      chk("rst_results", {25'd0, pf[d], af[d], bits[d], ppn[d], lvl[d]}, 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    run(0, 42'h0_0040_0001, 0, 1, 22'h0, 3, "t1_root_af");
    run(0, 42'h0_0080_0000, 0, 1, 22'h0, 0, "t1_leaf_af");
    for (int k = 0; k < 5; k++)
      run(0, (42'(3+k) << 22) | 42'h155000, 0, 1, 22'h0, 3, "t2_mega");
    run(0, 42'h0_0200_1000, 0, 1, 22'h0, 0, "t2_4k");
    run(0, 42'h0_0240_0000, 0, 1, 22'h0, 3, "t3_misalign");
    for (int k = 10; k < 13; k++) run(0, 42'(k) << 22, 0, 1, 22'h0, 3, "t4_l1_bad");
    for (int j = 0; j < 4; j++) run(0, (42'd13 << 22) | (42'(j) << 12), 0, 1, 22'h0, 0, "t4_l0_bad");
    run(0, 42'h0_0380_0000, 0, 1, 22'h0, 3, "t5_a0");
    run(0, 42'h0_03C0_0000, 1, 1, 22'h0, 3, "t5_d0_write");
    run(0, 42'h0_03C0_0000, 0, 1, 22'h0, 3, "t5_d0_read");
    run(0, 42'h0_1234_5001, 0, 0, 22'h0, 1, "t6_bare2");
    run(1, 42'h1_AA95_5000, 1, 1, 22'h3, 3, "t6_giga");
    run(1, 42'h2_0140_6000, 0, 1, 22'h3, 0, "t6_3level");
    run(1, 42'h3_0000_0000, 0, 1, 22'h3, 3, "t6_giga_misalign");
    run(1, 42'h3_1234_5001, 0, 0, 22'h3, 1, "t6_bare3");

    // Reset in the middle of a walk: bus drops at once, no done follows.
    @(posedge clk); #1;
    req[0] = 1'b1; va2 = 32'h0200_1000; mode[0] = 1'b1; root[0] = 22'h0; wr[0] = 1'b0;
    @(posedge clk); #1 req[0] = 1'b0;
    chk("midwalk_txn_before", 64'(txn[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("midwalk_txn_dropped", 64'(txn[0]), 64'd0);
    chk("midwalk_no_done", 64'(done[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    run(0, 42'h0_00D5_5000, 0, 1, 22'h0, 3, "after_reset");
    repeat (3) @(posedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
